// File: rtl/v2_queue_ctrl.sv
// Control logic for a shift-register queue: it drives the write and shift strobes of an
// external register array where entry 0 is always the head.
module v2_queue_ctrl #(
    parameter int p_depth    = 32,
    parameter int p_idwidth  = $clog2(p_depth),
    parameter int p_bitwidth = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enq_val,
    output logic                                  enq_rdy,
    input  logic [p_bitwidth-1:0]                 enq_msg,
    output logic                                  deq_val,
    input  logic                                  deq_rdy,
    output logic [p_bitwidth-1:0]                 deq_msg,
    input  logic                                  flush,
    output logic [p_idwidth:0]                    count,
    output logic [p_depth-1:0]                    wr_data,
    output logic [p_bitwidth-1:0]                 wr_data_in,
    output logic [p_depth-1:0][1:0]               shift_en,
    input  logic [p_depth-1:0][p_bitwidth-1:0]    data_out
);

    localparam int cw = p_idwidth + 1;
    localparam logic [p_idwidth:0] depth_c = cw'(p_depth);

    typedef enum logic [1:0] {
        sh_hold = 2'b00,
        sh_fwd  = 2'b01,
        sh_back = 2'b10
    } shift_t;

    logic             enq_fire;
    logic             deq_fire;
    logic [p_idwidth:0] wr_idx;

    assign enq_rdy    = (count < depth_c) && !flush;
    assign deq_val    = (count != '0) && !flush;
    assign deq_msg    = data_out[0];
    assign wr_data_in = enq_msg;
    assign enq_fire   = enq_val && enq_rdy;
    assign deq_fire   = deq_val && deq_rdy;

    // With a simultaneous dequeue the array shifts down first, so the new tail lands one slot lower.
    assign wr_idx = deq_fire ? count - cw'(1) : count;

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        wr_data  = '0;
        shift_en = '0;
        if (!rst) begin
            for (int i = 0; i < p_depth; i++) begin
                if (deq_fire && (cw'(i + 1) < count))
                    shift_en[i] = sh_back;
                if (enq_fire && (cw'(i) == wr_idx))
                    wr_data[i] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (flush)
            count <= '0;
        else begin
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_v2_queue_ctrl.sv
// Bench for v2_queue_ctrl: a behavioural register array feeds data_out, and a queue model
// predicts every output from the enqueue/dequeue/flush rules.
module tb_v2_queue_ctrl;

    localparam int D  = 4;
    localparam int IW = $clog2(D);
    localparam int W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enq_val;
    logic                    enq_rdy;
    logic [W-1:0]            enq_msg;
    logic                    deq_val;
    logic                    deq_rdy;
    logic [W-1:0]            deq_msg;
    logic                    flush;
    logic [IW:0]             count;
    logic [D-1:0]            wr_data;
    logic [W-1:0]            wr_data_in;
    logic [D-1:0][1:0]       shift_en;
    logic [D-1:0][W-1:0]     data_out = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    v2_queue_ctrl #(.p_depth(D), .p_idwidth(IW), .p_bitwidth(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .enq_msg    (enq_msg),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_msg    (deq_msg),
        .flush      (flush),
        .count      (count),
        .wr_data    (wr_data),
        .wr_data_in (wr_data_in),
        .shift_en   (shift_en),
        .data_out   (data_out)
    );

    // Register array the controller steers; entry 0 is the head.
    always @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (wr_data[i])
                data_out[i] <= wr_data_in;
            else if (shift_en[i] == 2'b10 && i < D - 1)
                data_out[i] <= data_out[i+1];
            else if (shift_en[i] == 2'b01 && i > 0)
                data_out[i] <= data_out[i-1];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the queue model, advance the model.
    task automatic step(input logic ev, input logic [W-1:0] em, input logic dr, input logic fl);
        int           sz;
        logic         e_rdy, d_val, e_f, d_f;
        logic [D-1:0] exp_wr;
        logic [D-1:0][1:0] exp_sh;
        @(negedge clk);
        enq_val = ev; enq_msg = em; deq_rdy = dr; flush = fl;
        #1;
        sz    = q.size();
        e_rdy = (sz < D) && !fl;
        d_val = (sz != 0) && !fl;
        e_f   = ev && e_rdy;
        d_f   = dr && d_val;
        check("count", 64'(count), 64'(sz));
        check("enq_rdy", 64'(enq_rdy), 64'(e_rdy));
        check("deq_val", 64'(deq_val), 64'(d_val));
        check("wr_data_in", 64'(wr_data_in), 64'(em));
        if (d_val)
            check("deq_msg", 64'(deq_msg), 64'(q[0]));
        exp_sh = '0;
        if (d_f)
            for (int i = 0; i < sz - 1; i++) exp_sh[i] = 2'b10;
        if (fl)
            q.delete();
        else begin
            if (d_f) void'(q.pop_front());
            if (e_f) q.push_back(em);
        end
        exp_wr = '0;
        if (e_f)
            exp_wr[q.size() - 1] = 1'b1;
        check("wr_data", 64'(wr_data), 64'(exp_wr));
        check("shift_en", 64'(shift_en), 64'(exp_sh));
        @(posedge clk);
    endtask

    task automatic expect_state(input string tag, input int cnt, input logic [W-1:0] head);
        #2;
        check({tag, "_count"}, 64'(count), 64'(cnt));
        if (cnt != 0)
            check({tag, "_head"}, 64'(deq_msg), 64'(head));
    endtask

    initial begin
        rst = 1'b1; enq_val = 1'b1; enq_msg = 8'h33; deq_rdy = 1'b1; flush = 1'b0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_enq_rdy", 64'(enq_rdy), 64'd1);
        check("rst_deq_val", 64'(deq_val), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_shift_en", 64'(shift_en), 64'd0);
        @(negedge clk);
        rst = 1'b0; enq_val = 1'b0; deq_rdy = 1'b0;
        @(posedge clk);

        // Three enqueues then three dequeues.
        step(1, 8'h0A, 0, 0); step(1, 8'h0B, 0, 0); step(1, 8'h0C, 0, 0);
        expect_state("fill3", 3, 8'h0A);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        expect_state("drain3", 0, 8'h00);
        step(0, 0, 0, 0);

        // Full: enqueue blocked even with a dequeue.
        for (int i = 1; i <= D; i++) step(1, W'(i), 0, 0);
        step(1, 8'h55, 1, 0);
        expect_state("full_deq", 3, 8'h02);
        step(0, 0, 0, 0);

        // Simultaneous enqueue and dequeue at count 2.
        step(0, 0, 0, 1);
        step(1, 8'h05, 0, 0); step(1, 8'h06, 0, 0);
        step(1, 8'h07, 1, 0);
        expect_state("simul", 2, 8'h06);
        step(0, 0, 1, 0);
        expect_state("simul_next", 1, 8'h07);
        step(0, 0, 1, 0);

        // Empty: dequeue blocked even with an enqueue.
        step(1, 8'h44, 1, 0);
        expect_state("empty_enq", 1, 8'h44);

        // Flush with both handshakes requesting.
        step(1, 8'h11, 0, 0); step(1, 8'h12, 0, 0);
        step(1, 8'h13, 1, 1);
        expect_state("flush", 0, 8'h00);

        // Asynchronous reset between edges.
        step(1, 8'h21, 0, 0); step(1, 8'h22, 0, 0);
        enq_val = 1'b0; deq_rdy = 1'b0; flush = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_deq_val", 64'(deq_val), 64'd0);
        #2 rst = 1'b0;
        q.delete();
        step(1, 8'h09, 0, 0);
        expect_state("arst_enq", 1, 8'h09);

        // Randomised traffic.
        for (int n = 0; n < 600; n++)
            step(($urandom_range(0, 9) < 6), W'($urandom), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 31) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
